// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op codes, flag layout and helpers for the execute stage
package alu_pkg;

  localparam int ALU_W = 64;

  typedef enum logic [2:0] {
    OP_PASS_B = 3'b000,
    OP_ADD    = 3'b010,
    OP_SUB    = 3'b011,
    OP_AND    = 3'b100,
    OP_OR     = 3'b101,
    OP_XOR    = 3'b110
  } alu_op_e;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } flags_t;

  function automatic logic is_legal_op(alu_op_e op);
    return (op == OP_PASS_B) || (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_AND)    || (op == OP_OR)  || (op == OP_XOR);
  endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - 64-bit combinational alu; C on SUB is the no-borrow carry of a + ~b + 1
import alu_pkg::*;

module alu (
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  logic [2:0]       cntrl,
  output logic [ALU_W-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  logic [ALU_W:0] w_sum;

  always_comb begin
    w_sum     = '0;
    result    = '0;
    carry_out = 1'b0;
    overflow  = 1'b0;
    case (cntrl)
      OP_PASS_B: result = b;
      OP_ADD: begin
        w_sum     = {1'b0, a} + {1'b0, b};
        result    = w_sum[ALU_W-1:0];
        carry_out = w_sum[ALU_W];
        overflow  = (a[ALU_W-1] == b[ALU_W-1]) && (result[ALU_W-1] != a[ALU_W-1]);
      end
      OP_SUB: begin
        w_sum     = {1'b0, a} + {1'b0, ~b} + {{ALU_W{1'b0}}, 1'b1};
        result    = w_sum[ALU_W-1:0];
        carry_out = w_sum[ALU_W];
        overflow  = (a[ALU_W-1] != b[ALU_W-1]) && (result[ALU_W-1] != a[ALU_W-1]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/exec_skid_buf.sv
// rtl/exec_skid_buf.sv - 2-entry FIFO skid buffer; built only when ALU_EXEC_SKID_EN is defined
`ifdef ALU_EXEC_SKID_EN
module exec_skid_buf #(
  parameter int DATA_W = 75
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_flush,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic              o_valid,
  output logic              o_ready,
  output logic [DATA_W-1:0] o_data
);

  localparam logic [1:0] S_EMPTY = 2'b00;
  localparam logic [1:0] S_ONE   = 2'b01;
  localparam logic [1:0] S_TWO   = 2'b10;

  logic [1:0]        r_state;
  logic [DATA_W-1:0] r_head;
  logic [DATA_W-1:0] r_tail;

  // r_head is always the oldest entry; r_tail only holds the second one in TWO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
      r_head  <= '0;
      r_tail  <= '0;
    end else if (i_flush) begin
      r_state <= S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (i_push) begin
            r_head  <= i_data;
            r_state <= S_ONE;
          end
        end
        S_ONE: begin
          if (i_push && i_pop) begin
            r_head <= i_data;
          end else if (i_push) begin
            r_tail  <= i_data;
            r_state <= S_TWO;
          end else if (i_pop) begin
            r_state <= S_EMPTY;
          end
        end
        S_TWO: begin
          if (i_pop) begin
            r_head  <= r_tail;
            r_state <= S_ONE;
          end
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

  assign o_valid = (r_state != S_EMPTY);
  assign o_ready = (r_state != S_TWO);
  assign o_data  = r_head;

endmodule
`endif

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - execute stage: alu + registered CDB output + NZVC flag register
// ALU_EXEC_SKID_EN selects a 2-entry skid buffer instead of the single output register.
import alu_pkg::*;

module alu_exec_stage #(
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [ALU_W-1:0] in_a,
  input  logic [ALU_W-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             in_set_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ALU_W-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       out_flags,
  output logic             out_err,
  output logic [3:0]       flags_q
);

  localparam int ENTRY_W = 1 + 4 + TAG_W + ALU_W;

  logic [ALU_W-1:0]   w_alu_result;
  logic               w_carry;
  logic               w_ovf;
  logic               w_legal;
  logic               w_arith;
  logic [ALU_W-1:0]   w_result;
  flags_t             w_flags;
  logic               w_push;
  logic [ENTRY_W-1:0] w_entry;
  logic [3:0]         r_flags_q;

  alu u_alu (
    .a         (in_a),
    .b         (in_b),
    .cntrl     (in_op),
    .result    (w_alu_result),
    .carry_out (w_carry),
    .overflow  (w_ovf)
  );

  assign w_legal  = is_legal_op(alu_op_e'(in_op));
  assign w_arith  = (in_op == OP_ADD) || (in_op == OP_SUB);
  assign w_result = w_legal ? w_alu_result : '0;

  always_comb begin
    w_flags   = '0;
    w_flags.n = w_result[ALU_W-1];
    w_flags.z = (w_result == '0);
    w_flags.v = w_arith & w_ovf;
    w_flags.c = w_arith & w_carry;
  end

  assign w_entry = {~w_legal, w_flags, in_tag, w_result};
  assign w_push  = in_valid & in_ready;

  // Flags commit at issue so a dependent op issued next cycle already sees them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags_q <= '0;
    end else if (w_push && in_set_flags && w_legal) begin
      r_flags_q <= w_flags;
    end
  end

  assign flags_q = r_flags_q;

`ifdef ALU_EXEC_SKID_EN
  logic               w_sb_valid;
  logic               w_sb_ready;
  logic [ENTRY_W-1:0] w_sb_data;

  exec_skid_buf #(
    .DATA_W (ENTRY_W)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (flush),
    .i_push  (w_push),
    .i_data  (w_entry),
    .i_pop   (out_ready),
    .o_valid (w_sb_valid),
    .o_ready (w_sb_ready),
    .o_data  (w_sb_data)
  );

  assign in_ready = w_sb_ready & ~flush;
  assign out_valid = w_sb_valid;
  assign {out_err, out_flags, out_tag, out_result} = w_sb_data;
`else
  logic               r_valid;
  logic [ENTRY_W-1:0] r_entry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_entry <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_push) begin
      r_valid <= 1'b1;
      r_entry <= w_entry;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign in_ready = ~flush & (~r_valid | out_ready);
  assign out_valid = r_valid;
  assign {out_err, out_flags, out_tag, out_result} = r_entry;
`endif

endmodule
